// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
//   SPI (mode 0, MSB first) frame receiver. Each chip-select window carries a
//   16-bit frame {rw, addr[6:0], data[7:0]}. Well-formed write frames addressed
//   at or below ADDR_MAX are queued in a 2-entry FIFO that feeds a register
//   bank through a valid/ready handshake. The SPI pins are treated as fully
//   asynchronous and are synchronized into the clk domain before use.
//
// Optional feature:
//   SPI_OVERRUN_CNT_EN - adds ovr_count, a saturating count of frame_err and
//                        overrun events.
//
// Parameters:
//   SYNC_STAGES  flip-flops per input synchronizer (2 or 3)
//   ADDR_MAX     highest register address accepted
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   sclk       SPI clock (mode 0)
//   copi       SPI data, MSB first
//   ncs        SPI chip select, active-low
//   wr_valid   a write is available at the FIFO head
//   wr_ready   downstream accepts the head entry
//   wr_addr    address of the head entry
//   wr_data    data of the head entry
//   frame_err  one-cycle pulse when a frame is discarded
//   overrun    one-cycle pulse when a valid frame is dropped on a full FIFO
//   ovr_count  (SPI_OVERRUN_CNT_EN only) saturating error/overrun count
// -----------------------------------------------------------------------------
module spi_frame_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] ADDR_MAX    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       overrun
`ifdef SPI_OVERRUN_CNT_EN
    ,
    output logic [7:0] ovr_count
`endif
);

    localparam int LIVE_W = SYNC_STAGES + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [4:0] bit_cnt_inc(input logic [4:0] c);
        return (c >= 5'd17) ? 5'd17 : c + 5'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? 8'hFF : c + 8'd1;
    endfunction

    // Stage p0: synchronizer chains; stage p1: edge-detect registers
    logic [SYNC_STAGES-1:0] sclk_p0, copi_p0, ncs_p0;
    logic                   sclk_p1, ncs_p1;
    // Fills with ones after reset; once full, both ncs_p0's output and ncs_p1
    // hold genuinely sampled values, so a low ncs on leaving reset cannot
    // masquerade as a falling edge against the reset value.
    logic [LIVE_W-1:0]      live;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;

    assign sclk_s    = sclk_p0[SYNC_STAGES-1];
    assign copi_s    = copi_p0[SYNC_STAGES-1];
    assign ncs_s     = ncs_p0[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_p1;
    assign ncs_fall  = live[LIVE_W-1] & ncs_p1 & ~ncs_s;
    assign ncs_rise  = ncs_s & ~ncs_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p0 <= '0;
            copi_p0 <= '0;
            ncs_p0  <= '1;
            sclk_p1 <= 1'b0;
            ncs_p1  <= 1'b1;
            live    <= '0;
        end else begin
            sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], sclk};
            copi_p0 <= {copi_p0[SYNC_STAGES-2:0], copi};
            ncs_p0  <= {ncs_p0[SYNC_STAGES-2:0], ncs};
            sclk_p1 <= sclk_s;
            ncs_p1  <= ncs_s;
            live    <= {live[LIVE_W-2:0], 1'b1};
        end
    end

    // Frame assembly and commit decision
    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;

    logic [1:0]  fifo_cnt;
    logic        wr_ptr, rd_ptr;
    logic [14:0] fifo_mem [2];

    logic frame_ok, push, pop, push_ok;

    assign frame_ok = (bit_cnt == 5'd16) && shreg[15] && (shreg[14:8] <= ADDR_MAX);
    assign push     = (state == COMMIT) && frame_ok;
    assign pop      = wr_valid && wr_ready;
    // A pop on the same edge frees a slot, so a full FIFO still takes the push.
    assign push_ok  = push && ((fifo_cnt != 2'd2) || pop);

`ifdef SPI_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_count <= 8'h00;
        end else if ((state == COMMIT) && (!frame_ok || !push_ok)) begin
            ovr_count <= sat_inc8(ovr_count);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= 16'h0000;
            bit_cnt   <= 5'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state   <= SHIFT;
                        shreg   <= 16'h0000;
                        bit_cnt <= 5'd0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[14:0], copi_s};
                        bit_cnt <= bit_cnt_inc(bit_cnt);
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    frame_err <= !frame_ok;
                    overrun   <= push && !push_ok;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage boundary: 2-entry FIFO toward the register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt    <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= 15'h0000;
            fifo_mem[1] <= 15'h0000;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= shreg[14:0];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign wr_valid = (fifo_cnt != 2'd0);
    assign wr_addr  = fifo_mem[rd_ptr][14:8];
    assign wr_data  = fifo_mem[rd_ptr][7:0];

endmodule

// File: tb/tb_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_rx
//   Directed bench for spi_frame_rx. A queue-based model of the write FIFO,
//   fed by the frames the stimulus sends, is compared against the DUT on every
//   falling clk edge; scenario-level literal checks pin the model.
//   Define SPI_OVERRUN_CNT_EN to also exercise ovr_count.
// -----------------------------------------------------------------------------
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       wr_ready = 1'b0;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       overrun;
`ifdef SPI_OVERRUN_CNT_EN
    logic [7:0] ovr_count;
`endif

    spi_frame_rx dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .copi     (copi),
        .ncs      (ncs),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .overrun  (overrun)
`ifdef SPI_OVERRUN_CNT_EN
        ,
        .ovr_count(ovr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    logic [14:0] mq[$];        // expected FIFO contents {addr, data}
    logic [14:0] pops[$];      // DUT handshakes observed {addr, data}
    int          cd = 0;       // edges until the pending frame commits
    logic [16:0] pend_val;
    int          pend_n;
    logic        exp_err = 1'b0;
    logic        exp_ovr = 1'b0;
    int          exp_evt = 0;
    int          err_seen = 0;
    int          ovr_seen = 0;
    int          vcycles  = 0;
    bit          m_pop, m_push;

    function automatic bit frame_ok(input logic [16:0] v, input int n);
        return (n == 16) && v[15] && (v[14:8] <= 7'h04);
    endfunction

    // Compare process: outputs are checked on the falling edge, then the
    // model is advanced to describe the state after the next rising edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
            chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
            chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
            chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
            chk("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef SPI_OVERRUN_CNT_EN
            chk("rst_ovr_count", {24'd0, ovr_count}, 32'd0);
`endif
            mq.delete();
            cd      = 0;
            exp_err = 1'b0;
            exp_ovr = 1'b0;
            exp_evt = 0;
        end else begin
            chk("wr_valid", {31'd0, wr_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("wr_addr", {25'd0, wr_addr}, {25'd0, mq[0][14:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, mq[0][7:0]});
            end
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
            chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
`ifdef SPI_OVERRUN_CNT_EN
            chk("ovr_count", {24'd0, ovr_count}, (exp_evt > 255) ? 32'd255 : exp_evt);
`endif
            if (frame_err) err_seen++;
            if (overrun) ovr_seen++;
            if (wr_valid) vcycles++;
            if (wr_valid && wr_ready) pops.push_back({wr_addr, wr_data});

            m_pop   = (mq.size() != 0) && wr_ready;
            m_push  = 1'b0;
            exp_err = 1'b0;
            exp_ovr = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (!frame_ok(pend_val, pend_n)) exp_err = 1'b1;
                    else if (mq.size() == 2 && !m_pop) exp_ovr = 1'b1;
                    else m_push = 1'b1;
                end
            end
            if (exp_err || exp_ovr) exp_evt++;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(pend_val[14:0]);
        end
    end

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bits(input logic [16:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    // Sends one frame; ready_pulse holds wr_ready high only across the edge
    // on which this frame commits (4th edge after ncs is sampled high).
    task automatic frame(input logic [16:0] v, input int n, input bit ready_pulse);
        ncs = 1'b0;
        tick(4);
        spi_bits(v, n);
        tick(4);
        ncs      = 1'b1;
        pend_val = v;
        pend_n   = n;
        cd       = 4;
        if (ready_pulse) begin
            tick(3);
            wr_ready = 1'b1;
            tick(1);
            wr_ready = 1'b0;
            tick(4);
        end else begin
            tick(8);
        end
    endtask

    int e0, o0, v0, p0;

    task automatic snap();
        e0 = err_seen;
        o0 = ovr_seen;
        v0 = vcycles;
        p0 = pops.size();
    endtask

    initial begin
        tick(3);
        chk("reset_wr_valid_lit", {31'd0, wr_valid}, 32'd0);
        chk("reset_wr_data_lit", {24'd0, wr_data}, 32'd0);
        rst = 1'b0;
        tick(6);

        // Scenario 1: single write, immediate acceptance
        wr_ready = 1'b1;
        snap();
        frame(17'h08155, 16, 1'b0);
        tick(4);
        chk("s1_valid_cycles", vcycles - v0, 1);
        chk("s1_pops", pops.size() - p0, 1);
        chk("s1_entry", {17'd0, pops[p0]}, {17'd0, 7'h01, 8'h55});
        chk("s1_err", err_seen - e0, 0);

        // Scenario 2: read frame is discarded
        snap();
        frame(17'h00155, 16, 1'b0);
        tick(4);
        chk("s2_err", err_seen - e0, 1);
        chk("s2_valid_cycles", vcycles - v0, 0);

        // Scenario 3: short, long and out-of-range frames
        snap();
        frame(17'h04155, 15, 1'b0);
        frame(17'h18155, 17, 1'b0);
        frame(17'h08500, 16, 1'b0);
        tick(4);
        chk("s3_err", err_seen - e0, 3);
        chk("s3_pops", pops.size() - p0, 0);
        chk("s3_valid_cycles", vcycles - v0, 0);

        // Scenario 4: overrun on the third frame, then ordered drain
        wr_ready = 1'b0;
        snap();
        frame(17'h08011, 16, 1'b0);
        frame(17'h08122, 16, 1'b0);
        frame(17'h08233, 16, 1'b0);
        chk("s4_overrun", ovr_seen - o0, 1);
        chk("s4_err", err_seen - e0, 0);
        wr_ready = 1'b1;
        tick(6);
        chk("s4_pops", pops.size() - p0, 2);
        chk("s4_first", {17'd0, pops[p0]}, {17'd0, 7'h00, 8'h11});
        chk("s4_second", {17'd0, pops[p0+1]}, {17'd0, 7'h01, 8'h22});

        // Scenario 5: reset mid-frame, released with ncs still low
        snap();
        ncs = 1'b0;
        tick(4);
        spi_bits(17'h00081, 8);
        rst = 1'b1;
        tick(3);
        chk("s5_rst_valid", {31'd0, wr_valid}, 32'd0);
        rst = 1'b0;
        spi_bits(17'h00099, 8);
        tick(4);
        ncs = 1'b1;
        tick(12);
        chk("s5_err", err_seen - e0, 0);
        chk("s5_pops", pops.size() - p0, 0);
        frame(17'h08477, 16, 1'b0);
        tick(4);
        chk("s5_pops_after", pops.size() - p0, 1);
        chk("s5_entry", {17'd0, pops[p0]}, {17'd0, 7'h04, 8'h77});

        // Simultaneous pop and push with the FIFO full
        wr_ready = 1'b0;
        snap();
        frame(17'h08066, 16, 1'b0);
        frame(17'h08177, 16, 1'b0);
        frame(17'h08288, 16, 1'b1);
        chk("full_pp_overrun", ovr_seen - o0, 0);
        chk("full_pp_popped", pops.size() - p0, 1);
        wr_ready = 1'b1;
        tick(6);
        chk("full_pp_pops", pops.size() - p0, 3);
        chk("full_pp_0", {17'd0, pops[p0]}, {17'd0, 7'h00, 8'h66});
        chk("full_pp_1", {17'd0, pops[p0+1]}, {17'd0, 7'h01, 8'h77});
        chk("full_pp_2", {17'd0, pops[p0+2]}, {17'd0, 7'h02, 8'h88});

        // Simultaneous pop and push with one entry
        wr_ready = 1'b0;
        snap();
        frame(17'h08199, 16, 1'b0);
        frame(17'h08300, 16, 1'b1);
        chk("one_pp_valid", {31'd0, wr_valid}, 32'd1);
        chk("one_pp_head", {17'd0, wr_addr, wr_data}, {17'd0, 7'h03, 8'h00});
        wr_ready = 1'b1;
        tick(4);
        chk("one_pp_pops", pops.size() - p0, 2);
        chk("one_pp_0", {17'd0, pops[p0]}, {17'd0, 7'h01, 8'h99});
        chk("one_pp_1", {17'd0, pops[p0+1]}, {17'd0, 7'h03, 8'h00});

`ifdef SPI_OVERRUN_CNT_EN
        // Scenario 6: counter saturation
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        for (int i = 0; i < 300; i++) frame(17'h00155, 16, 1'b0);
        tick(2);
        chk("s6_ovr_count", {24'd0, ovr_count}, 32'h0000_00FF);
`endif

        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
